// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data-memory bus for loads/stores, stalls on
// wait states, aborts after TIMEOUT wait cycles, and fills the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ExMem_AluResult,
  input  logic [31:0] ExMem_AluB_Pc4,
  input  logic [31:0] ExMem_StoreData,
  input  logic [2:0]  ExMem_Funct3,
  input  logic        ExMem_MemRead,
  input  logic        ExMem_MemWrite,
  input  logic        ExMem_MemToReg,
  input  logic [4:0]  ExMem_RegRd,
  input  logic        ExMem_RegWrite,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [3:0]  DMem_Be,
  output logic [31:0] DMem_WData,
  input  logic        DMem_Ready,
  input  logic [31:0] DMem_RData,
  output logic        Mem_Stall,
  output logic [31:0] MemWb_MemData,
  output logic [31:0] MemWb_AluB_Pc4,
  output logic        MemWb_MemToReg,
  output logic [4:0]  MemWb_RegRd,
  output logic        MemWb_RegWrite,
  output logic        Mem_ErrMisalign,
  output logic        Mem_ErrTimeout
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // The abort fires on the TIMEOUT-th WAIT cycle (counter runs 0..TIMEOUT-1).
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        w_pending;
  logic        w_is_wr;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_legal;
  logic        w_bad;
  logic        w_abort;
  logic        w_done;
  logic [1:0]  w_off;
  logic [31:0] w_load;

  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = 32'(signed'(b));
      3'b001:  r = 32'(signed'(h));
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0]  sz,
                                              input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] sz,
                                              input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    w_off     = ExMem_AluResult[1:0];
    w_pending = ExMem_MemRead | ExMem_MemWrite;
    w_is_wr   = ExMem_MemWrite;
    case (ExMem_Funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !w_is_wr;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misalign = ((ExMem_Funct3[1:0] == 2'b01) && w_off[0]) ||
                 ((ExMem_Funct3[1:0] == 2'b10) && (w_off != 2'b00));
    w_legal    = w_pending & w_f3_ok & !w_misalign;
    w_bad      = w_pending & !w_legal;
    w_abort    = (r_state == S_WAIT) & !DMem_Ready & (r_cnt == LP_LAST);
    w_done     = w_legal & DMem_Ready;
    w_load     = load_extract(DMem_RData, w_off, ExMem_Funct3);

    // Bus outputs follow the held EX/MEM fields, so they stay stable through WAIT.
    DMem_Req   = w_legal & !rst;
    DMem_We    = DMem_Req & w_is_wr;
    DMem_Addr  = {ExMem_AluResult[31:2], 2'b00};
    DMem_Be    = byte_enables(ExMem_Funct3[1:0], w_off);
    DMem_WData = store_lanes(ExMem_Funct3[1:0], ExMem_StoreData);
    Mem_Stall  = w_legal & !DMem_Ready & !w_abort & !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 8'd0;
          if (w_legal && !DMem_Ready) r_state <= S_WAIT;
        end
        default: begin
          if (!w_legal || DMem_Ready || w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // MEM/WB boundary: any access that does not complete this cycle becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemWb_MemData   <= 32'd0;
      MemWb_AluB_Pc4  <= 32'd0;
      MemWb_MemToReg  <= 1'b0;
      MemWb_RegRd     <= 5'd0;
      MemWb_RegWrite  <= 1'b0;
      Mem_ErrMisalign <= 1'b0;
      Mem_ErrTimeout  <= 1'b0;
    end else begin
      MemWb_AluB_Pc4  <= ExMem_AluB_Pc4;
      MemWb_MemToReg  <= ExMem_MemToReg;
      MemWb_RegRd     <= ExMem_RegRd;
      MemWb_MemData   <= 32'd0;
      MemWb_RegWrite  <= 1'b0;
      Mem_ErrMisalign <= w_bad;
      Mem_ErrTimeout  <= w_abort;
      if (!w_pending) begin
        MemWb_RegWrite <= ExMem_RegWrite;
      end else if (w_done && !w_is_wr) begin
        MemWb_MemData  <= w_load;
        MemWb_RegWrite <= ExMem_RegWrite;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a transaction-level model of the stage.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ExMem_AluResult, ExMem_AluB_Pc4, ExMem_StoreData;
  logic [2:0]  ExMem_Funct3;
  logic        ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_RegWrite;
  logic [4:0]  ExMem_RegRd;
  logic        DMem_Req, DMem_We, DMem_Ready;
  logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
  logic [3:0]  DMem_Be;
  logic        Mem_Stall;
  logic [31:0] MemWb_MemData, MemWb_AluB_Pc4;
  logic        MemWb_MemToReg, MemWb_RegWrite, Mem_ErrMisalign, Mem_ErrTimeout;
  logic [4:0]  MemWb_RegRd;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ExMem_AluResult(ExMem_AluResult), .ExMem_AluB_Pc4(ExMem_AluB_Pc4),
    .ExMem_StoreData(ExMem_StoreData), .ExMem_Funct3(ExMem_Funct3),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_MemToReg(ExMem_MemToReg), .ExMem_RegRd(ExMem_RegRd),
    .ExMem_RegWrite(ExMem_RegWrite),
    .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
    .DMem_Be(DMem_Be), .DMem_WData(DMem_WData), .DMem_Ready(DMem_Ready),
    .DMem_RData(DMem_RData), .Mem_Stall(Mem_Stall),
    .MemWb_MemData(MemWb_MemData), .MemWb_AluB_Pc4(MemWb_AluB_Pc4),
    .MemWb_MemToReg(MemWb_MemToReg), .MemWb_RegRd(MemWb_RegRd),
    .MemWb_RegWrite(MemWb_RegWrite), .Mem_ErrMisalign(Mem_ErrMisalign),
    .Mem_ErrTimeout(Mem_ErrTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input logic rd_, input logic wr_, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] alub, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic rdy,
                        input logic [31:0] rdata);
    ExMem_MemRead   = rd_;
    ExMem_MemWrite  = wr_;
    ExMem_Funct3    = f3;
    ExMem_AluResult = addr;
    ExMem_StoreData = sd;
    ExMem_AluB_Pc4  = alub;
    ExMem_RegRd     = rd;
    ExMem_RegWrite  = rw;
    ExMem_MemToReg  = m2r;
    DMem_Ready      = rdy;
    DMem_RData      = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Transaction-level model: access size in bytes, legality, and how many
  // consecutive cycles the current access has been stalled.
  int          m_waited = 0;
  bit          have_exp = 0;
  logic        e_rw, e_mis, e_to, e_md_v, e_fld_v, e_m2r;
  logic [31:0] e_md, e_alub;
  logic [4:0]  e_rd;

  always @(negedge clk) begin
    int          sz, off;
    bit          pend, isw, f3ok, ok, abort, stall;
    logic [31:0] v, wexp;
    if (have_exp) begin
      chk("m_regwrite", 32'(MemWb_RegWrite), 32'(e_rw));
      chk("m_errmis", 32'(Mem_ErrMisalign), 32'(e_mis));
      chk("m_errto", 32'(Mem_ErrTimeout), 32'(e_to));
      if (e_md_v) chk("m_memdata", MemWb_MemData, e_md);
      if (e_fld_v) begin
        chk("m_alub", MemWb_AluB_Pc4, e_alub);
        chk("m_rd", 32'(MemWb_RegRd), 32'(e_rd));
        chk("m_m2r", 32'(MemWb_MemToReg), 32'(e_m2r));
      end
    end
    have_exp = 1;
    pend = ExMem_MemRead || ExMem_MemWrite;
    isw  = ExMem_MemWrite;
    f3ok = (ExMem_Funct3 <= 3'd2) || (!isw && (ExMem_Funct3 == 3'd4 || ExMem_Funct3 == 3'd5));
    sz   = 1 << ExMem_Funct3[1:0];
    off  = int'(ExMem_AluResult % 4);
    ok   = pend && f3ok && ((ExMem_AluResult % sz) == 0);
    abort = ok && !DMem_Ready && (m_waited == TO);
    stall = ok && !DMem_Ready && !abort;
    if (rst) begin
      chk("m_req_rst", 32'(DMem_Req), 32'd0);
      chk("m_stall_rst", 32'(Mem_Stall), 32'd0);
      {e_rw, e_mis, e_to, e_m2r} = '0;
      e_md = '0; e_alub = '0; e_rd = '0;
      e_md_v = 1; e_fld_v = 1;
      m_waited = 0;
    end else begin
      chk("m_req", 32'(DMem_Req), 32'(ok));
      chk("m_stall", 32'(Mem_Stall), 32'(stall));
      if (ok) begin
        chk("m_addr", DMem_Addr, ExMem_AluResult - off);
        chk("m_be", 32'(DMem_Be), ((32'd1 << sz) - 1) << off);
        chk("m_we", 32'(DMem_We), 32'(isw));
        if (isw) begin
          for (int i = 0; i < 4; i++) wexp[8*i +: 8] = ExMem_StoreData[8*(i % sz) +: 8];
          chk("m_wdata", DMem_WData, wexp);
        end
      end
      e_mis = pend && !ok;
      e_to = abort;
      e_alub = ExMem_AluB_Pc4; e_rd = ExMem_RegRd; e_m2r = ExMem_MemToReg;
      e_fld_v = !pend;
      e_md_v = 0; e_md = 0; e_rw = 0;
      if (!pend) begin
        e_rw = ExMem_RegWrite; e_md_v = 1;
      end else if (ok && DMem_Ready && !isw) begin
        v = DMem_RData >> (8 * off);
        if (sz == 1) v = v & 32'hFF;
        if (sz == 2) v = v & 32'hFFFF;
        if (!ExMem_Funct3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!ExMem_Funct3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
        e_md = v; e_md_v = 1; e_rw = ExMem_RegWrite;
      end
      m_waited = stall ? m_waited + 1 : 0;
    end
  end

  initial begin
    rst = 1'b1;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("rst_req", 32'(DMem_Req), 32'd0);
    chk("rst_stall", 32'(Mem_Stall), 32'd0);
    chk("rst_regwrite", 32'(MemWb_RegWrite), 32'd0);
    chk("rst_errs", 32'({Mem_ErrMisalign, Mem_ErrTimeout}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Non-access op with a stray Ready.
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    chk("nop_alub", MemWb_AluB_Pc4, 32'h1234);
    chk("nop_rd", 32'(MemWb_RegRd), 32'd5);
    chk("nop_rw", 32'(MemWb_RegWrite), 32'd1);
    chk("nop_md", MemWb_MemData, 32'd0);
    // Zero-wait LW.
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h55, 5'd7, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    #1;
    chk("lw_req", 32'(DMem_Req), 32'd1);
    chk("lw_stall", 32'(Mem_Stall), 32'd0);
    chk("lw_be", 32'(DMem_Be), 32'hF);
    step();
    chk("lw_md", MemWb_MemData, 32'hDEADBEEF);
    chk("lw_rw", 32'(MemWb_RegWrite), 32'd1);
    // LB with three wait cycles.
    set_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h80112233);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_stall", 32'(Mem_Stall), 32'd1);
      step();
      chk("lb_bubble", 32'(MemWb_RegWrite), 32'd0);
    end
    DMem_Ready = 1'b1;
    #1;
    chk("lb_done_stall", 32'(Mem_Stall), 32'd0);
    chk("lb_be", 32'(DMem_Be), 32'b1000);
    step();
    chk("lb_md", MemWb_MemData, 32'hFFFFFF80);
    chk("lb_rw", 32'(MemWb_RegWrite), 32'd1);
    // SH at 0x102.
    set_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    chk("sh_be", 32'(DMem_Be), 32'b1100);
    chk("sh_wdata", DMem_WData, 32'hABCDABCD);
    chk("sh_addr", DMem_Addr, 32'h100);
    chk("sh_we", 32'(DMem_We), 32'd1);
    step();
    chk("sh_rw", 32'(MemWb_RegWrite), 32'd0);
    // Misaligned LW.
    set_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    chk("mis_req", 32'(DMem_Req), 32'd0);
    step();
    nop();
    #1;
    chk("mis_err", 32'(Mem_ErrMisalign), 32'd1);
    chk("mis_rw", 32'(MemWb_RegWrite), 32'd0);
    step();
    chk("mis_err_pulse", 32'(Mem_ErrMisalign), 32'd0);
    // Store with an unsigned size code is illegal.
    set_op(1'b0, 1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("ill_req", 32'(DMem_Req), 32'd0);
    step();
    // Read and write together behave as a store.
    set_op(1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 32'h0);
    #1;
    chk("ill_err", 32'(Mem_ErrMisalign), 32'd1);
    chk("rw_we", 32'(DMem_We), 32'd1);
    chk("rw_wdata", DMem_WData, 32'h11223344);
    step();
    chk("rw_rw", 32'(MemWb_RegWrite), 32'd0);
    // LHU / LH at 0x102 and SB at 0x101.
    set_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 32'h80017FFF);
    step();
    chk("lhu_md", MemWb_MemData, 32'h00008001);
    set_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 32'h80017FFF);
    step();
    chk("lh_md", MemWb_MemData, 32'hFFFF8001);
    set_op(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 5'd15, 1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("sb_be", 32'(DMem_Be), 32'b0010);
    chk("sb_wdata", DMem_WData, 32'h78787878);
    step();
    // Timeout: Ready never comes.
    set_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd16, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("to_stall", 32'(Mem_Stall), 32'd1);
      step();
    end
    #1;
    chk("to_abort_stall", 32'(Mem_Stall), 32'd0);
    chk("to_abort_req", 32'(DMem_Req), 32'd1);
    step();
    nop();
    #1;
    chk("to_err", 32'(Mem_ErrTimeout), 32'd1);
    chk("to_rw", 32'(MemWb_RegWrite), 32'd0);
    step();
    chk("to_err_pulse", 32'(Mem_ErrTimeout), 32'd0);
    set_op(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h0, 5'd17, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D);
    #1;
    chk("to_idle_stall", 32'(Mem_Stall), 32'd0);
    step();
    chk("to_idle_md", MemWb_MemData, 32'hCAFEF00D);
    // Reset in the middle of a wait.
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h777, 5'd18, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstw_req", 32'(DMem_Req), 32'd0);
    chk("rstw_stall", 32'(Mem_Stall), 32'd0);
    chk("rstw_alub", MemWb_AluB_Pc4, 32'd0);
    step();
    rst = 1'b0;
    nop();
    step();
    step();
    chk("rstw_errto", 32'(Mem_ErrTimeout), 32'd0);
    chk("rstw_req_after", 32'(DMem_Req), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
